// File: rtl/apb_host_bridge_pkg.sv
// rtl/apb_host_bridge_pkg.sv - shared types and widths for the APB host bridge
package apb_host_bridge_pkg;

    localparam int APB_DATA_W   = 32;
    localparam int APB_TO_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS wait-state counter with limit compare
// Ports: clk_i/rst_i clock and sync active-high reset; clr_i zeroes the count;
//        en_i counts one wait cycle; limit_i compare value; expired_o count == limit.
module apb_wait_timer
    import apb_host_bridge_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [APB_TO_CNT_W-1:0] limit_i,
    output logic                    expired_o
);

    logic [APB_TO_CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt <= '0;
        end else if (en_i && (cnt != '1)) begin
            // Saturate so a stalled compare can never wrap back below the limit.
            cnt <= cnt + 1'b1;
        end
    end

    assign expired_o = (cnt == limit_i);

endmodule

// File: rtl/apb_host_bridge.sv
// rtl/apb_host_bridge.sv - req/gnt host port to single-slave APB3 master bridge
// Optional watchdog: define APB_HOST_BRIDGE_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES wait states with an error response.
// Ports: clk_i, rst_i (sync active-high); host side req_i/we_i/addr_i/wdata_i,
//        gnt_o, rvalid_o/rdata_o/err_o; APB side paddr_o/pwdata_o/pwrite_o/
//        psel_o/penable_o, prdata_i/pready_i/pslverr_i.
module apb_host_bridge
    import apb_host_bridge_pkg::*;
#(
    parameter int PADDR_W        = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [APB_DATA_W-1:0] wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [APB_DATA_W-1:0] rdata_o,
    output logic                  err_o,
    output logic [PADDR_W-1:0]    paddr_o,
    output logic [APB_DATA_W-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [APB_DATA_W-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    apb_state_e state, state_next;
    logic       xfer_done;
    logic       xfer_abort;

    // Decode of the upper address bits belongs to the interconnect.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:PADDR_W];

    assign xfer_done = (state == ACCESS) && pready_i;

`ifdef APB_HOST_BRIDGE_TIMEOUT_EN
    logic to_expired;

    apb_wait_timer u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state == SETUP),
        .en_i      ((state == ACCESS) && !pready_i),
        .limit_i   (APB_TO_CNT_W'(TIMEOUT_CYCLES)),
        .expired_o (to_expired)
    );

    // A ready arriving on the limit cycle wins: that is a normal completion.
    assign xfer_abort = (state == ACCESS) && !pready_i && to_expired;
`else
    assign xfer_abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_o) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (xfer_done || xfer_abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        gnt_o     = 1'b0;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        case (state)
            IDLE:    gnt_o = req_i && !rst_i;
            SETUP:   psel_o = 1'b1;
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture and one-cycle response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            paddr_o  <= '0;
            pwdata_o <= '0;
            pwrite_o <= 1'b0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            if (gnt_o) begin
                paddr_o  <= addr_i[PADDR_W-1:0];
                pwdata_o <= wdata_i;
                pwrite_o <= we_i;
            end
            rvalid_o <= xfer_done || xfer_abort;
            rdata_o  <= (xfer_done && !pwrite_o) ? prdata_i : '0;
            err_o    <= xfer_done ? pslverr_i : xfer_abort;
        end
    end

endmodule
